histogram_accumulator: RTL and testbench

Builds the 256-bin intensity histogram that the histogram derivative stage consumes. Pixels stream in one per cycle during a frame and increment working bins. At frame end the working bins are copied into a published bank. The downstream derivative logic therefore always sees a complete, stable histogram while the next frame accumulates.

---
 rtl/histogram_accumulator.sv | 131 +++++++++++++
 tb/tb_histogram_accumulator.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/histogram_accumulator.sv
// Streaming 256-bin intensity histogram. Working bins accumulate one pixel per cycle.
// At frame end the working bins are copied into a published bank that stays stable while the next frame runs.
module histogram_accumulator #(
    parameter int PIXEL_W = 8,
    parameter int COUNT_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_pixel_valid,
    input  logic [PIXEL_W-1:0] i_pixel,
    input  logic               i_frame_end,
    output logic [COUNT_W-1:0] o_histogram [0:2**PIXEL_W-1],
    output logic               o_saturated,
    output logic               o_busy,
    output logic               o_done,
    output logic [15:0]        o_frame_count
);

    localparam int NBINS = 2**PIXEL_W;
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        FLUSH   = 2'd2,
        PUBLISH = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               p_valid_q, p_valid_d;
    logic [PIXEL_W-1:0] p_pixel_q, p_pixel_d;
    logic [COUNT_W-1:0] work_q [0:NBINS-1];
    logic [COUNT_W-1:0] work_d [0:NBINS-1];
    logic [COUNT_W-1:0] pub_q  [0:NBINS-1];
    logic [COUNT_W-1:0] pub_d  [0:NBINS-1];
    logic               sat_q, sat_d;
    logic               saturated_q, saturated_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [15:0]        frame_count_q, frame_count_d;
    logic               inc_en;

    // A restart in ACCUM wipes the bins, so the in-flight pixel must not land on top of the clear.
    assign inc_en = p_valid_q && ((state_q == ACCUM && !i_start) || state_q == FLUSH);

    always_comb begin
        state_d       = state_q;
        work_d        = work_q;
        pub_d         = pub_q;
        sat_d         = sat_q;
        saturated_d   = saturated_q;
        frame_count_d = frame_count_q;
        p_valid_d     = i_pixel_valid && (state_q == ACCUM) && !i_start;
        p_pixel_d     = i_pixel;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    for (int i = 0; i < NBINS; i++) work_d[i] = '0;
                    sat_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (i_start) begin
                    for (int i = 0; i < NBINS; i++) work_d[i] = '0;
                    sat_d = 1'b0;
                end else if (i_frame_end) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                state_d = PUBLISH;
            end
            PUBLISH: begin
                pub_d         = work_q;
                saturated_d   = sat_q;
                frame_count_d = frame_count_q + 16'd1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (inc_en) begin
            if (work_q[p_pixel_q] == COUNT_MAX) begin
                sat_d = 1'b1;
            end else begin
                work_d[p_pixel_q] = work_q[p_pixel_q] + COUNT_W'(1);
            end
        end

        busy_d = (state_d != IDLE);
        done_d = (state_q == PUBLISH);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= IDLE;
            p_valid_q     <= 1'b0;
            p_pixel_q     <= '0;
            for (int i = 0; i < NBINS; i++) begin
                work_q[i] <= '0;
                pub_q[i]  <= '0;
            end
            sat_q         <= 1'b0;
            saturated_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            p_valid_q     <= p_valid_d;
            p_pixel_q     <= p_pixel_d;
            work_q        <= work_d;
            pub_q         <= pub_d;
            sat_q         <= sat_d;
            saturated_q   <= saturated_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign o_histogram   = pub_q;
    assign o_saturated   = saturated_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_frame_count = frame_count_q;

endmodule

// File: tb/tb_histogram_accumulator.sv
// Directed self-checking bench for histogram_accumulator.
// Inputs change 1ns after each rising edge, so outputs are sampled well away from the edge.
module tb_histogram_accumulator;

    logic        clk;
    logic        rst;
    logic        start;
    logic        pixel_valid;
    logic [7:0]  pixel;
    logic        frame_end;
    logic [15:0] histogram [0:255];
    logic        saturated;
    logic        busy;
    logic        done;
    logic [15:0] frame_count;

    int vectors;
    int miscompares;

    histogram_accumulator #(.PIXEL_W(8), .COUNT_W(16)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_pixel_valid (pixel_valid),
        .i_pixel       (pixel),
        .i_frame_end   (frame_end),
        .o_histogram   (histogram),
        .o_saturated   (saturated),
        .o_busy        (busy),
        .o_done        (done),
        .o_frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and advance to just after the next rising edge.
    task automatic applyStimulus(input logic s, input logic v, input logic [7:0] p, input logic fe);
        start       = s;
        pixel_valid = v;
        pixel       = p;
        frame_end   = fe;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int nonzeroBins();
        int n = 0;
        for (int i = 0; i < 256; i++) if (histogram[i] !== 16'd0) n++;
        return n;
    endfunction

    function automatic int sumBins();
        int s = 0;
        for (int i = 0; i < 256; i++) s += int'(histogram[i]);
        return s;
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        start       = 1'b0;
        pixel_valid = 1'b0;
        pixel       = 8'd0;
        frame_end   = 1'b0;

        // Reset asserted before any clock edge must clear outputs immediately.
        #3;
        rst = 1'b1;
        #1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_sat", 32'(saturated), 32'd0);
        checkOutput("reset_count", 32'(frame_count), 32'd0);
        checkOutput("reset_nonzero_bins", 32'(nonzeroBins()), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        $display("[TB] reset released");

        // Basic frame: 0,0,5,255 with frame_end on 255.
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        checkOutput("basic_busy_accum", 32'(busy), 32'd1);
        applyStimulus(1'b0, 1'b1, 8'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'd5, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'd255, 1'b1);
        checkOutput("basic_done_flush", 32'(done), 32'd0);
        checkOutput("basic_busy_flush", 32'(busy), 32'd1);
        idleCycle();
        checkOutput("basic_done_publish", 32'(done), 32'd0);
        checkOutput("basic_bin0_stable", 32'(histogram[0]), 32'd0);
        idleCycle();
        checkOutput("basic_done_pulse", 32'(done), 32'd1);
        checkOutput("basic_bin0", 32'(histogram[0]), 32'd2);
        checkOutput("basic_bin5", 32'(histogram[5]), 32'd1);
        checkOutput("basic_bin255", 32'(histogram[255]), 32'd1);
        checkOutput("basic_nonzero_bins", 32'(nonzeroBins()), 32'd3);
        checkOutput("basic_sum", 32'(sumBins()), 32'd4);
        checkOutput("basic_count", 32'(frame_count), 32'd1);
        checkOutput("basic_busy_idle", 32'(busy), 32'd0);
        idleCycle();
        checkOutput("basic_done_one_cycle", 32'(done), 32'd0);

        // Gating: pixels while IDLE and invalid pixels are ignored.
        applyStimulus(1'b0, 1'b1, 8'd9, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'd9, 1'b0);
        checkOutput("gate_idle_busy", 32'(busy), 32'd0);
        applyStimulus(1'b1, 1'b1, 8'd9, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'd9, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'd9, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'd9, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'd9, 1'b1);
        idleCycle();
        idleCycle();
        checkOutput("gate_done", 32'(done), 32'd1);
        checkOutput("gate_bin9", 32'(histogram[9]), 32'd3);
        checkOutput("gate_bin0", 32'(histogram[0]), 32'd0);
        checkOutput("gate_bin255", 32'(histogram[255]), 32'd0);
        checkOutput("gate_sum", 32'(sumBins()), 32'd3);
        checkOutput("gate_count", 32'(frame_count), 32'd2);
        checkOutput("gate_sat", 32'(saturated), 32'd0);

        // Saturation: 65537 pixels of value 7 must clamp at 65535.
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 65536; i++) applyStimulus(1'b0, 1'b1, 8'd7, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'd7, 1'b1);
        idleCycle();
        idleCycle();
        checkOutput("sat_bin7", 32'(histogram[7]), 32'd65535);
        checkOutput("sat_flag", 32'(saturated), 32'd1);
        checkOutput("sat_count", 32'(frame_count), 32'd3);
        checkOutput("sat_bin9_cleared", 32'(histogram[9]), 32'd0);
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'd1, 1'b1);
        idleCycle();
        idleCycle();
        checkOutput("nosat_flag", 32'(saturated), 32'd0);
        checkOutput("nosat_bin1", 32'(histogram[1]), 32'd1);
        checkOutput("nosat_bin7", 32'(histogram[7]), 32'd0);
        checkOutput("nosat_count", 32'(frame_count), 32'd4);

        // Abort: frame A publishes bin3=4, frame B restarts mid-way.
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'd3, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'd3, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'd3, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'd3, 1'b1);
        idleCycle();
        idleCycle();
        checkOutput("abortA_bin3", 32'(histogram[3]), 32'd4);
        checkOutput("abortA_count", 32'(frame_count), 32'd5);
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'd3, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'd3, 1'b0);
        checkOutput("abortB_holds_A", 32'(histogram[3]), 32'd4);
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        checkOutput("abortB_restart_done", 32'(done), 32'd0);
        checkOutput("abortB_restart_busy", 32'(busy), 32'd1);
        applyStimulus(1'b0, 1'b1, 8'd4, 1'b1);
        checkOutput("abortB_flush_done", 32'(done), 32'd0);
        idleCycle();
        checkOutput("abortB_publish_done", 32'(done), 32'd0);
        checkOutput("abortB_still_A", 32'(histogram[3]), 32'd4);
        checkOutput("abortB_count_hold", 32'(frame_count), 32'd5);
        idleCycle();
        checkOutput("abortB_done", 32'(done), 32'd1);
        checkOutput("abortB_bin3", 32'(histogram[3]), 32'd0);
        checkOutput("abortB_bin4", 32'(histogram[4]), 32'd1);
        checkOutput("abortB_sum", 32'(sumBins()), 32'd1);
        checkOutput("abortB_count", 32'(frame_count), 32'd6);

        // Reset mid-frame discards the partial frame and clears outputs at once.
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 8'd2, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_count", 32'(frame_count), 32'd0);
        checkOutput("midrst_sat", 32'(saturated), 32'd0);
        checkOutput("midrst_nonzero_bins", 32'(nonzeroBins()), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'd2, 1'b1);
        idleCycle();
        idleCycle();
        checkOutput("postrst_bin2", 32'(histogram[2]), 32'd1);
        checkOutput("postrst_sum", 32'(sumBins()), 32'd1);
        checkOutput("postrst_count", 32'(frame_count), 32'd1);
        checkOutput("postrst_done", 32'(done), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
